seq_multiplier_16_bit: RTL and testbench



---
 rtl/mult_pkg.sv | 16 +
 rtl/multiplier_4_bit.sv | 10 +
 rtl/seq_multiplier_16_bit.sv | 128 ++++++++++++
 tb/tb_seq_multiplier_16_bit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative nibble-serial multiplier.
package mult_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned iter_count(input int unsigned n_digits);
    return n_digits * n_digits;
  endfunction

endpackage

// File: rtl/multiplier_4_bit.sv
// Combinational 4x4 unsigned multiplier producing an 8-bit product.
module multiplier_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/seq_multiplier_16_bit.sv
// Iterative unsigned multiplier: one 4x4 multiplier is reused over every nibble pair and the
// shifted partial products are summed into a product-width accumulator.
module seq_multiplier_16_bit
  import mult_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_W*N_DIGITS-1:0] a,
  input  logic [DIGIT_W*N_DIGITS-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DIGIT_W*N_DIGITS-1:0] p
);

  localparam int unsigned OP_W  = DIGIT_W * N_DIGITS;
  localparam int unsigned P_W   = 2 * OP_W;
  localparam int unsigned CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned SH_W  = $clog2(P_W);
  localparam int unsigned ITERS = iter_count(N_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  state_t           r_state, w_state_d;
  logic [OP_W-1:0]  r_a, w_a_d;
  logic [OP_W-1:0]  r_b, w_b_d;
  logic [P_W-1:0]   r_acc, w_acc_d;
  logic [P_W-1:0]   r_p, w_p_d;
  logic [CNT_W-1:0] r_i, w_i_d;
  logic [CNT_W-1:0] r_j, w_j_d;

  logic [DIGIT_W-1:0]   w_a_nib;
  logic [DIGIT_W-1:0]   w_b_nib;
  logic [2*DIGIT_W-1:0] w_prod;
  logic [SH_W-1:0]      w_shamt;
  logic [P_W-1:0]       w_partial;
  logic [P_W-1:0]       w_sum;

  assign w_a_nib = r_a[r_i*DIGIT_W +: DIGIT_W];
  assign w_b_nib = r_b[r_j*DIGIT_W +: DIGIT_W];

  multiplier_4_bit u_mul (
    .a (w_a_nib),
    .b (w_b_nib),
    .p (w_prod)
  );

  // Widen before adding the digit indices so i+j cannot wrap in CNT_W bits.
  assign w_shamt   = SH_W'(DIGIT_W) * (SH_W'(r_i) + SH_W'(r_j));
  assign w_partial = {{(P_W - 2 * DIGIT_W){1'b0}}, w_prod} << w_shamt;
  assign w_sum     = r_acc + w_partial;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign p         = r_p;

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_acc_d   = r_acc;
    w_p_d     = r_p;
    w_i_d     = r_i;
    w_j_d     = r_j;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_d     = a;
          w_b_d     = b;
          w_acc_d   = '0;
          w_i_d     = '0;
          w_j_d     = '0;
          w_state_d = CALC;
        end
      end
      CALC: begin
        w_acc_d = w_sum;
        if (r_j == LAST_DIGIT) begin
          w_j_d = '0;
          if (r_i == LAST_DIGIT) begin
            w_i_d     = '0;
            w_p_d     = w_sum;
            w_state_d = DONE;
          end else begin
            w_i_d = r_i + CNT_W'(1);
          end
        end else begin
          w_j_d = r_j + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_acc   <= w_acc_d;
      r_p     <= w_p_d;
      r_i     <= w_i_d;
      r_j     <= w_j_d;
    end
  end

  // ITERS is the number of CALC edges between accept and out_valid.
  logic [31:0] w_iters_unused;
  assign w_iters_unused = 32'(ITERS);

endmodule

// File: tb/tb_seq_multiplier_16_bit.sv
// Scoreboard bench: expected products are queued on accept and checked when the DUT delivers.
module tb_seq_multiplier_16_bit;

  localparam int LAT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;

  int          tests = 0;
  int          fails = 0;
  int          n_done = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          busy = 1'b0;
  bit          prev_ov = 1'b0;
  bit          rand_bp = 1'b0;
  logic [31:0] sb_q[$];

  seq_multiplier_16_bit #(.N_DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Abort of an in-flight operation: nothing it queued may ever be delivered.
  always @(negedge rst_n) begin
    busy    = 1'b0;
    prev_ov = 1'b0;
    sb_q.delete();
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) check("in_ready_low_while_busy", {31'b0, in_ready}, 32'd0);
      if (out_valid && !prev_ov) check("latency", 32'(cyc - acc_cyc), 32'(LAT));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got 0x%08h expected no output", p);
        end else begin
          check("product", p, sb_q.pop_front());
        end
        busy = 1'b0;
        n_done++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(32'(a) * 32'(b));
        acc_cyc = cyc + 1;
        busy    = 1'b1;
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    int k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int start = n_done;
    int k = 0;
    while (n_done == start && k < 300) begin
      tick();
      k++;
    end
    if (n_done == start) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got no output expected one");
    end
  endtask

  // Random back-pressure generator, active only while rand_bp is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          k;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("reset_p", p, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    send(16'h0003, 16'h0005);
    wait_result();
    check("basic_p", p, 32'h0000_000F);

    send(16'hFFFF, 16'hFFFF);
    wait_result();
    check("full_scale_p", p, 32'hFFFE_0001);

    send(16'h1234, 16'hABCD);
    wait_result();
    check("mixed_p", p, 32'h0C37_4FA4);

    send(16'h0000, 16'h0000);
    wait_result();
    check("zero_p", p, 32'h0000_0000);

    // Back-pressure: result held, new operands refused until the product is taken.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0100);
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    a        = 16'h0003;
    b        = 16'h0004;
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      check("bp_p_held", p, 32'h0000_FF00);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_result();
    tick();
    in_valid = 1'b0;
    wait_result();
    check("after_bp_p", p, 32'h0000_000C);

    // Asynchronous reset part-way through CALC.
    send(16'h1111, 16'h2222);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_p", p, 32'd0);
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rst_n    = 1'b1;
    a        = 16'd2;
    b        = 16'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result();
    check("post_reset_p", p, 32'd14);

    // Operand isolation: input changes during CALC must not leak in.
    send(16'h0010, 16'h0010);
    tick();
    a = 16'hFFFF;
    b = 16'hFFFF;
    wait_result();
    check("isolation_p", p, 32'h0000_0100);

    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 5) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 16'h0000;
      send(ra, rb);
      wait_result();
    end
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
